fp_to_fixed: RTL and testbench
==============================

Name: fp_to_fixed

Overview:
- Converts an IEEE-754 single-precision value (normally the `fpadd` sum) into a saturated two's-complement fixed-point sample for the audio output path.
- Sits directly downstream of `fpadd` and uses the same start protocol: deasserting `reset` starts one conversion, and `done` flags completion.
- Multi-cycle: the mantissa is shifted one bit per clock, so no wide barrel shifter is needed.

Parameters:
- WIDTH, 16: output width in bits; legal range 8..32.
- FRAC_BITS, 15: fractional bits of the output format (default is Q1.15); legal range 0..WIDTH-1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset; its deassertion starts a conversion.
- dataa  in  32  IEEE-754 single input; sampled on the first rising edge after reset deasserts.
- result  out  WIDTH  signed fixed-point output, equal to round(dataa * 2^FRAC_BITS) with saturation.
- done  out  1  high once `result` is valid; stays high until the next reset.

Behaviour:
- Reset: the block is driven asynchronously to LOAD; `result` = 0, `done` = 0, and all internal registers are cleared.
- Asserting `reset` mid-conversion aborts it immediately; no partial result is ever shown.
- LOAD (first edge with reset low):
  - latch sign s, exponent e, and mantissa m = {1, frac} (24 bits) into a 32-bit accumulator;
  - compute sh = e - 150 + FRAC_BITS as a signed 10-bit value.
- Classification at LOAD:
  - e == 0 (zero or denormal): flush to zero; go to FINISH with accumulator = 0.
  - e == 255 with frac != 0 (NaN): saturate to +max.
  - e == 255 with frac == 0 (infinity): saturate according to s.
  - sh > WIDTH-25: saturate according to s.
  - sh < -23: value is 0; go to FINISH.
  - otherwise: load cnt = |sh| and go to SHIFT, or go directly to FINISH if cnt == 0.
- SHIFT: shift the accumulator one bit per cycle, right if sh < 0 and left if sh > 0; decrement cnt; go to FINISH when cnt reaches 0.
- FINISH (one cycle), in this order:
  - apply optional rounding;
  - clamp the magnitude: if it exceeds 2^(WIDTH-1)-1, the result is +max (0x7FFF) for s=0 and -2^(WIDTH-1) (0x8000) for s=1;
  - negate if s = 1;
  - register `result` and set `done` = 1; go to DONE.
- DONE: hold `result` and `done`; ignore `dataa`.
- Latency: done rises (1 + |sh| + 1) edges after reset falls, or 2 edges for special/saturate/zero cases. Worst case at defaults is 25 cycles.
- Sign of zero: -0.0 gives 0.
- Exact minimum: -1.0 at defaults saturates to 0x8000, which is also the exact value.

Optional Feature:
- FP_TO_FIXED_ROUND_NEAREST_EN defined:
  - track a sticky round bit (the last bit shifted out to the right);
  - FINISH adds it to the magnitude before clamping (round half away from zero);
  - a carry that overflows past the maximum saturates.
- Macro undefined: truncate toward zero; no round bit is held.
- Latency is identical in both builds.

Decomposition:
- Package `fp_pkg`: EXP_W=8, MANT_W=23, BIAS=127, the `fp_class_t` enum (ZERO, NORMAL, INF, NAN), and the state enum (LOAD, SHIFT, FINISH, DONE).
- Natural sub-module `fp_unpack`, combinational: splits the 32-bit word into sign, exponent and hidden-bit mantissa, and outputs its class. The adder can reuse it later.

Test Plan (all at defaults; each scenario pulses reset for 1 cycle, waits 30 cycles, then checks `done`==1 and `result`):
- 0x3F000000 (0.5) -> 0x4000, with done rising on edge 11; 0xBF000000 (-0.5) -> 0xC000.
- Saturation:
  - 0x3F800000 (1.0) -> 0x7FFF;
  - 0xBF800000 (-1.0) -> 0x8000;
  - 0x42C80000 (100.0) -> 0x7FFF;
  - 0xFF800000 (-inf) -> 0x8000;
  - 0x7FC00000 (NaN) -> 0x7FFF.
- Zero cases: 0x00000000 -> 0x0000; 0x80000001 (negative denormal) -> 0x0000; 0x33800000 (2^-24) -> 0x0000. Each has done on edge 2.
- Rounding with 0x3EAAAAAB (1/3):
  - truncating build -> 0x2AAA;
  - FP_TO_FIXED_ROUND_NEAREST_EN build -> 0x2AAB;
  - 0xBEAAAAAB gives 0xD556 and 0xD555 respectively.
- 0x3F7FFFFF -> 0x7FFF in both builds; in the rounding build the rounding carry must saturate, not wrap.
- Abort: start a conversion of 0x3E99999A, assert reset at cycle 5 -> `result`=0 and `done`=0 immediately. After release, convert 0x3E99999A (0.3) -> 0x2666.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision field widths, operand classes and converter states.
// Pure declarations; no logic, no latency.
// Used by fp_unpack and fp_to_fixed, and later by the adder.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int BIAS   = 127;

  typedef enum logic [1:0] {
    ZERO,
    NORMAL,
    INF,
    NAN
  } fp_class_t;

  typedef enum logic [1:0] {
    LOAD,
    SHIFT,
    FINISH,
    DONE
  } state_t;

endpackage

// File: rtl/fp_unpack.sv
// Splits an IEEE-754 single into sign, exponent, hidden-bit mantissa and class.
// Purely combinational, zero latency.
// No flow control; outputs follow the input word.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [EXP_W+MANT_W:0] word_i,
  output logic                  sign_o,
  output logic [EXP_W-1:0]      exp_o,
  output logic [MANT_W:0]       mant_o,
  output fp_class_t             cls_o
);

  logic [MANT_W-1:0] frac;

  // Field split and classification; denormals count as zero here.
  always_comb begin
    frac   = word_i[MANT_W-1:0];
    sign_o = word_i[EXP_W+MANT_W];
    exp_o  = word_i[EXP_W+MANT_W-1:MANT_W];
    mant_o = {(exp_o != '0), frac};
    if (exp_o == '0) begin
      cls_o = ZERO;
    end else if (exp_o == '1) begin
      cls_o = (frac != '0) ? NAN : INF;
    end else begin
      cls_o = NORMAL;
    end
  end

endmodule

// File: rtl/fp_to_fixed.sv
// Converts an IEEE-754 single to saturated signed fixed point (Q(WIDTH-FRAC_BITS).FRAC_BITS).
// Latency: 1 + |sh| + 1 edges after reset falls; 2 edges for zero/special/saturating inputs.
// No backpressure: reset release starts one conversion, done holds until next reset.
// Optional FP_TO_FIXED_ROUND_NEAREST_EN: round half away from zero instead of truncating.
module fp_to_fixed
  import fp_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             dataa,
  output logic signed [WIDTH-1:0] result,
  output logic                    done
);

  // Shift amount that lines the hidden-bit mantissa up with the output LSB.
  localparam logic signed [9:0] SH_BASE = 10'(BIAS + MANT_W - FRAC_BITS);
  localparam logic signed [9:0] SH_MAX  = 10'(WIDTH - 25);
  localparam logic signed [9:0] SH_MIN  = 10'(-23);
  localparam logic [32:0]       MAG_MAX = (33'd1 << (WIDTH - 1)) - 33'd1;
  localparam logic [WIDTH-1:0]  POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]  NEG_MAX = {1'b1, {(WIDTH-1){1'b0}}};

  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [MANT_W:0]   in_mant;
  fp_class_t         in_cls;

  state_t            state_q, state_d;
  logic              sign_q, sign_d;
  logic              left_q, left_d;
  logic [31:0]       acc_q, acc_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              done_q, done_d;
  logic              rnd_q;
`ifdef FP_TO_FIXED_ROUND_NEAREST_EN
  logic              rnd_d;
`endif

  logic signed [9:0] sh_c;
  logic [9:0]        sh_abs_c;
  logic [32:0]       mag_c;

  fp_unpack u_unpack (
    .word_i (dataa),
    .sign_o (in_sign),
    .exp_o  (in_exp),
    .mant_o (in_mant),
    .cls_o  (in_cls)
  );

  // Next-state logic: classify at LOAD, walk the shift, then round/clamp/negate once.
  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    left_d   = left_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = done_q;
`ifdef FP_TO_FIXED_ROUND_NEAREST_EN
    rnd_d    = rnd_q;
`endif
    sh_c     = $signed({2'b00, in_exp}) - SH_BASE;
    sh_abs_c = sh_c[9] ? 10'(-sh_c) : 10'(sh_c);
    mag_c    = {1'b0, acc_q} + {32'd0, rnd_q};

    unique case (state_q)
      LOAD: begin
        sign_d  = in_sign;
        left_d  = ~sh_c[9];
        acc_d   = {8'd0, in_mant};
        cnt_d   = sh_abs_c[4:0];
        state_d = FINISH;
        if (in_cls == ZERO) begin
          acc_d = '0;
        end else if (in_cls == NAN) begin
          // NaN has no meaningful sign; always report +max.
          sign_d = 1'b0;
          acc_d  = '1;
        end else if (in_cls == INF || sh_c > SH_MAX) begin
          // Any magnitude above MAG_MAX makes FINISH clamp by sign.
          acc_d = '1;
        end else if (sh_c < SH_MIN) begin
          acc_d = '0;
        end else if (sh_abs_c != 10'd0) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = left_q ? (acc_q << 1) : (acc_q >> 1);
`ifdef FP_TO_FIXED_ROUND_NEAREST_EN
        if (!left_q) rnd_d = acc_q[0];
`endif
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = FINISH;
      end
      FINISH: begin
        if (mag_c > MAG_MAX) begin
          result_d = sign_q ? NEG_MAX : POS_MAX;
        end else begin
          result_d = sign_q ? -mag_c[WIDTH-1:0] : mag_c[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = DONE;
      end
      default: state_d = LOAD;
    endcase
  end

  // State registers; reset aborts any conversion and clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= LOAD;
      sign_q   <= 1'b0;
      left_q   <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      left_q   <= left_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

`ifdef FP_TO_FIXED_ROUND_NEAREST_EN
  // Last bit shifted out to the right, added back at FINISH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rnd_q <= 1'b0;
    else       rnd_q <= rnd_d;
  end
`else
  assign rnd_q = 1'b0;
`endif

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_fp_to_fixed.sv
module tb_fp_to_fixed;

  logic               clk;
  logic               reset;
  logic [31:0]        dataa;
  logic signed [15:0] result;
  logic               done;

  int total;
  int bad;

`ifdef FP_TO_FIXED_ROUND_NEAREST_EN
  localparam logic [15:0] THIRD_POS = 16'h2AAB;
  localparam logic [15:0] THIRD_NEG = 16'hD555;
`else
  localparam logic [15:0] THIRD_POS = 16'h2AAA;
  localparam logic [15:0] THIRD_NEG = 16'hD556;
`endif

  typedef struct {
    logic [31:0] din;
    logic [15:0] res;
    int          edge_n;
    string       tag;
  } vec_t;

  vec_t vecs[13];

  fp_to_fixed #(.WIDTH(16), .FRAC_BITS(15)) dut (
    .clk    (clk),
    .reset  (reset),
    .dataa  (dataa),
    .result (result),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Pulse reset for one cycle, then watch up to 30 edges for done.
  task automatic run_vec(input logic [31:0] din, input logic [15:0] req,
                         input int req_edge, input string tag);
    int seen;
    seen = 0;
    @(negedge clk);
    reset = 1'b1;
    dataa = din;
    #1;
    check({tag, " rst_done"}, {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (done && seen == 0) begin
        seen = c;
        dataa = ~din;  // DONE must ignore the input from here on
      end
    end
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " result"}, {16'd0, result}, {16'd0, req});
    check({tag, " edge"}, 32'(seen), 32'(req_edge));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    dataa = 32'd0;

    vecs[0]  = '{32'h3F000000, 16'h4000, 11, "half"};
    vecs[1]  = '{32'hBF000000, 16'hC000, 11, "neg_half"};
    vecs[2]  = '{32'h3F800000, 16'h7FFF, 2,  "one"};
    vecs[3]  = '{32'hBF800000, 16'h8000, 2,  "neg_one"};
    vecs[4]  = '{32'h42C80000, 16'h7FFF, 2,  "hundred"};
    vecs[5]  = '{32'hFF800000, 16'h8000, 2,  "neg_inf"};
    vecs[6]  = '{32'h7FC00000, 16'h7FFF, 2,  "nan"};
    vecs[7]  = '{32'h00000000, 16'h0000, 2,  "zero"};
    vecs[8]  = '{32'h80000001, 16'h0000, 2,  "neg_denorm"};
    vecs[9]  = '{32'h33800000, 16'h0000, 2,  "tiny"};
    vecs[10] = '{32'h3EAAAAAB, THIRD_POS, 12, "third"};
    vecs[11] = '{32'hBEAAAAAB, THIRD_NEG, 12, "neg_third"};
    vecs[12] = '{32'h3F7FFFFF, 16'h7FFF, 11, "near_one"};

    #2;
    reset = 1'b1;
    #2;
    check("reset result", {16'd0, result}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);

    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i].din, vecs[i].res, vecs[i].edge_n, vecs[i].tag);
    end

    // Asynchronous clear of a finished result, away from any clock edge.
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async clr result", {16'd0, result}, 32'd0);
    check("async clr done", {31'd0, done}, 32'd0);

    // Abort a conversion of 0.3 at cycle 5.
    @(negedge clk);
    reset = 1'b0;
    dataa = 32'h3E99999A;
    for (int c = 1; c <= 5; c++) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort result", {16'd0, result}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort hold done", {31'd0, done}, 32'd0);

    run_vec(32'h3E99999A, 16'h2666, 12, "point3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
